// File: rtl/boids_pkg.sv
// Shared fixed-point types, screen-edge constants and FSM encoding for the boid pass scheduler.
package boids_pkg;

  localparam int unsigned W         = 27;
  localparam int unsigned FRAC_BITS = 15;

  typedef logic signed [W-1:0] fix_t;

  localparam fix_t FIX_MAX = fix_t'({1'b0, {(W-1){1'b1}}});
  localparam fix_t FIX_MIN = fix_t'({1'b1, {(W-1){1'b0}}});

  localparam fix_t EDGE_LEFT   = fix_t'(100 << FRAC_BITS);
  localparam fix_t EDGE_RIGHT  = fix_t'(540 << FRAC_BITS);
  localparam fix_t EDGE_TOP    = fix_t'(100 << FRAC_BITS);
  localparam fix_t EDGE_BOTTOM = fix_t'(380 << FRAC_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } sched_state_t;

  // Signed add in W+1 bits, clipped back into the fix_t range instead of wrapping.
  function automatic fix_t sat_add(input fix_t a, input fix_t b);
    logic signed [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) begin
      return s[W] ? FIX_MIN : FIX_MAX;
    end
    return fix_t'(s[W-1:0]);
  endfunction

endpackage

// File: rtl/boid_update_sched_if.sv
// Control, parameter and boid-memory signals between the scheduler (master) and its environment (slave).
interface boid_update_sched_if #(
  parameter int unsigned IDX_W = 6
);
  import boids_pkg::*;

  logic             start;
  fix_t             turnfactor;
  fix_t             maxspeed;
  logic             busy;
  logic             done;

  logic             rd_en;
  logic [IDX_W-1:0] rd_addr;
  fix_t             rd_x;
  fix_t             rd_y;
  fix_t             rd_vx;
  fix_t             rd_vy;

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  fix_t             wr_x;
  fix_t             wr_y;
  fix_t             wr_vx;
  fix_t             wr_vy;

  modport master (
    input  start, turnfactor, maxspeed,
    input  rd_x, rd_y, rd_vx, rd_vy,
    output busy, done,
    output rd_en, rd_addr,
    output wr_en, wr_addr, wr_x, wr_y, wr_vx, wr_vy
  );

  modport slave (
    output start, turnfactor, maxspeed,
    output rd_x, rd_y, rd_vx, rd_vy,
    input  busy, done,
    input  rd_en, rd_addr,
    input  wr_en, wr_addr, wr_x, wr_y, wr_vx, wr_vy
  );

endinterface

// File: rtl/bound_check.sv
// Screen-edge steering: nudges velocity back toward the interior when a boid is strictly past an edge.
module bound_check
  import boids_pkg::*;
(
  input  fix_t i_x,
  input  fix_t i_y,
  input  fix_t i_vx,
  input  fix_t i_vy,
  input  fix_t i_turnfactor,
  output fix_t o_vx_c,
  output fix_t o_vy_c
);

  fix_t w_neg_tf;

  assign w_neg_tf = fix_t'(-i_turnfactor);

  always_comb begin
    o_vx_c = i_vx;
    o_vy_c = i_vy;
    if (i_x < EDGE_LEFT) begin
      o_vx_c = sat_add(i_vx, i_turnfactor);
    end else if (i_x > EDGE_RIGHT) begin
      o_vx_c = sat_add(i_vx, w_neg_tf);
    end
    if (i_y < EDGE_TOP) begin
      o_vy_c = sat_add(i_vy, i_turnfactor);
    end else if (i_y > EDGE_BOTTOM) begin
      o_vy_c = sat_add(i_vy, w_neg_tf);
    end
  end

endmodule

// File: rtl/boid_update_sched.sv
// Per-frame pass over all boids: read state, steer off edges, clamp speed, advance position, write back.
module boid_update_sched
  import boids_pkg::*;
#(
  parameter int unsigned N_BOIDS = 64,
  parameter int unsigned IDX_W   = 6
) (
  input logic                 clk,
  input logic                 reset,
  boid_update_sched_if.master bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BOIDS - 1);

  sched_state_t     r_state;
  sched_state_t     w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  fix_t             r_turnfactor;
  fix_t             r_maxspeed;

  logic r_busy, r_done, r_rd_en, r_wr_en;
  logic w_busy_nxt, w_done_nxt, w_rd_en_nxt, w_wr_en_nxt;

  logic [IDX_W-1:0] r_wr_addr;
  fix_t             r_wr_x, r_wr_y, r_wr_vx, r_wr_vy;

  logic w_accept;
  logic w_last;
  fix_t w_vx_chk, w_vy_chk;
  fix_t w_vx_lim, w_vy_lim;
  fix_t w_neg_max;
  fix_t w_x_new, w_y_new;

  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_last   = (r_idx == LAST_IDX);

  // State register; outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_rd_en <= w_rd_en_nxt;
      r_wr_en <= w_wr_en_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_CALC;
      S_CALC:  w_state_nxt = S_WRITE;
      S_WRITE: w_state_nxt = w_last ? S_DONE : S_READ;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_rd_en_nxt = 1'b0;
    w_wr_en_nxt = 1'b0;
    case (w_state_nxt)
      S_READ:  begin w_busy_nxt = 1'b1; w_rd_en_nxt = 1'b1; end
      S_CALC:  w_busy_nxt = 1'b1;
      S_WRITE: begin w_busy_nxt = 1'b1; w_wr_en_nxt = 1'b1; end
      S_DONE:  begin w_busy_nxt = 1'b1; w_done_nxt = 1'b1; end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  bound_check u_bound_check (
    .i_x          (bus.rd_x),
    .i_y          (bus.rd_y),
    .i_vx         (bus.rd_vx),
    .i_vy         (bus.rd_vy),
    .i_turnfactor (r_turnfactor),
    .o_vx_c       (w_vx_chk),
    .o_vy_c       (w_vy_chk)
  );

  // Symmetric per-axis clamp; values exactly at +/-maxspeed pass through.
  assign w_neg_max = fix_t'(-r_maxspeed);
  assign w_vx_lim  = (w_vx_chk > r_maxspeed) ? r_maxspeed :
                     ((w_vx_chk < w_neg_max) ? w_neg_max : w_vx_chk);
  assign w_vy_lim  = (w_vy_chk > r_maxspeed) ? r_maxspeed :
                     ((w_vy_chk < w_neg_max) ? w_neg_max : w_vy_chk);
  assign w_x_new   = sat_add(bus.rd_x, w_vx_lim);
  assign w_y_new   = sat_add(bus.rd_y, w_vy_lim);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_turnfactor <= '0;
      r_maxspeed   <= '0;
      r_wr_addr    <= '0;
      r_wr_x       <= '0;
      r_wr_y       <= '0;
      r_wr_vx      <= '0;
      r_wr_vy      <= '0;
    end else begin
      if (w_accept) begin
        r_idx        <= '0;
        r_turnfactor <= bus.turnfactor;
        r_maxspeed   <= bus.maxspeed;
      end
      if (r_state == S_CALC) begin
        r_wr_addr <= r_idx;
        r_wr_x    <= w_x_new;
        r_wr_y    <= w_y_new;
        r_wr_vx   <= w_vx_lim;
        r_wr_vy   <= w_vy_lim;
      end
      if ((r_state == S_WRITE) && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_idx;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_x    = r_wr_x;
  assign bus.wr_y    = r_wr_y;
  assign bus.wr_vx   = r_wr_vx;
  assign bus.wr_vy   = r_wr_vy;

endmodule
